// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg
// Shared constants for the BCD display counter: BCD digit width,
// active-low seven-segment patterns {dp,g,f,e,d,c,b,a} with dp off,
// the all-off blank pattern, and a helper that forces an invalid
// BCD nibble to zero.
package bcd_disp_pkg;

   localparam int BCD_W = 4;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;

   // Nibbles above 9 are not BCD and are taken as zero.
   function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
      logic [3:0] res;
      if (nib > 4'd9) begin
         res = 4'd0;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd - 4-bit BCD digit (values above 9 decode to blank)
//   seg - 8-bit active-low pattern {dp,g,f,e,d,c,b,a}, dp always off
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   // Digit to segment lookup.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_display_counter.sv
// bcd_display_counter
// Prescaled BCD up/down counter driving a multiplexed, active-low
// seven-segment display with optional leading-zero blanking.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - count enable (prescaler advances only while high)
//   up_dn      - 1 counts up, 0 counts down
//   load       - synchronous load strobe, beats counting
//   load_val   - BCD load value, digit 0 in [3:0]
//   blank_lz   - blank leading zero digits (digit 0 never blanked)
//   value      - current BCD count
//   wrap       - one-cycle pulse on rollover / rollunder
//   ctrl       - active-low one-hot digit select (registered)
//   segment    - active-low {dp,g,f,e,d,c,b,a} (registered)
module bcd_display_counter
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1,
   parameter int REFRESH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   input  logic                    blank_lz,
   output logic [BCD_W*DIGITS-1:0] value,
   output logic                    wrap,
   output logic [DIGITS-1:0]       ctrl,
   output logic [7:0]              segment
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int RW = (REFRESH  > 1) ? $clog2(REFRESH)  : 1;
   localparam int DW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

   logic [PW-1:0]             psc_r;
   logic [RW-1:0]             ref_r;
   logic [DW-1:0]             dig_r;
   logic [BCD_W*DIGITS-1:0]   value_r;
   logic                      wrap_r;
   logic [DIGITS-1:0]         ctrl_r;
   logic [7:0]                seg_r;

   logic                      step_s;
   logic [BCD_W*DIGITS-1:0]   value_next_s;
   logic [BCD_W*DIGITS-1:0]   load_clean_s;
   logic                      chain_s;
   logic [3:0]                nib_s;
   logic [DIGITS-1:0]         lz_s;
   logic                      all_zero_s;
   logic                      blank_sel_s;
   logic [3:0]                sel_nib_s;
   logic [7:0]                pat_s;
   logic [DIGITS-1:0]         ctrl_next_s;

   assign step_s = en && (psc_r == PSC_LAST);

   // Per-digit BCD increment/decrement; chain_s is carry (up) or borrow (down)
   // and leaves the top digit set only on rollover/rollunder.
   always_comb begin
      value_next_s = value_r;
      chain_s      = 1'b1;
      nib_s        = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         nib_s = value_r[i*BCD_W +: BCD_W];
         if (chain_s) begin
            if (up_dn) begin
               if (nib_s == 4'd9) begin
                  nib_s = 4'd0;
               end else begin
                  nib_s   = nib_s + 4'd1;
                  chain_s = 1'b0;
               end
            end else begin
               if (nib_s == 4'd0) begin
                  nib_s = 4'd9;
               end else begin
                  nib_s   = nib_s - 4'd1;
                  chain_s = 1'b0;
               end
            end
         end else begin
            nib_s = value_r[i*BCD_W +: BCD_W];
         end
         value_next_s[i*BCD_W +: BCD_W] = nib_s;
      end
   end

   // Load value with non-BCD nibbles forced to zero.
   always_comb begin
      load_clean_s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         load_clean_s[i*BCD_W +: BCD_W] = bcd_sanitize(load_val[i*BCD_W +: BCD_W]);
      end
   end

   // lz_s[i] is set when digit i and every digit above it are zero.
   always_comb begin
      lz_s       = '0;
      all_zero_s = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero_s = all_zero_s && (value_r[i*BCD_W +: BCD_W] == 4'd0);
         lz_s[i]    = all_zero_s;
      end
   end

   // Selected digit, its blanking decision and the one-hot-low select.
   always_comb begin
      sel_nib_s   = value_r[dig_r*BCD_W +: BCD_W];
      blank_sel_s = blank_lz && (dig_r != '0) && lz_s[dig_r];
      ctrl_next_s = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_r == DW'(i)) begin
            ctrl_next_s[i] = 1'b0;
         end else begin
            ctrl_next_s[i] = 1'b1;
         end
      end
   end

   seg7_decode u_dec (
      .bcd (sel_nib_s),
      .seg (pat_s)
   );

   // Counter, prescaler and wrap pulse: rst > load > step.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r <= '0;
         psc_r   <= '0;
         wrap_r  <= 1'b0;
      end else if (load) begin
         value_r <= load_clean_s;
         psc_r   <= '0;
         wrap_r  <= 1'b0;
      end else begin
         wrap_r <= step_s && chain_s;
         if (step_s) begin
            value_r <= value_next_s;
            psc_r   <= '0;
         end else if (en) begin
            psc_r   <= psc_r + PW'(1);
         end else begin
            psc_r   <= psc_r;
         end
      end
   end

   // Digit scan timer, free running regardless of en and load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_r <= '0;
         dig_r <= '0;
      end else if (ref_r == REF_LAST) begin
         ref_r <= '0;
         if (dig_r == DIG_LAST) begin
            dig_r <= '0;
         end else begin
            dig_r <= dig_r + DW'(1);
         end
      end else begin
         ref_r <= ref_r + RW'(1);
      end
   end

   // Display outputs, one cycle behind the scan index and value.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r <= '1;
         seg_r  <= SEG_BLANK;
      end else begin
         ctrl_r <= ctrl_next_s;
         seg_r  <= blank_sel_s ? SEG_BLANK : pat_s;
      end
   end

   assign value   = value_r;
   assign wrap    = wrap_r;
   assign ctrl    = ctrl_r;
   assign segment = seg_r;

endmodule
